// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: parametrised sequence-memory game core.
// The game replays a loadable one-hot sequence and checks button presses against it.
// Round r needs r+1 correct plays. The game is won at the round given by limite,
// and each play must arrive within TIMEOUT_CYC cycles.
module jogo_memoria_param #(
  parameter int unsigned NBOT        = 4,
  parameter int unsigned MAXSEQ      = 16,
  parameter int unsigned TIMEOUT_CYC = 5000,
  parameter int unsigned SHOW_CYC    = 1000,
  parameter int unsigned GAP_CYC     = 250,
  localparam int unsigned AW         = (MAXSEQ > 1) ? $clog2(MAXSEQ) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            jogar,
  input  logic            modo_mostra,
  input  logic [AW-1:0]   limite,
  input  logic [NBOT-1:0] botoes,
  input  logic            carrega,
  input  logic [AW-1:0]   end_carga,
  input  logic [NBOT-1:0] dado_carga,
  output logic [NBOT-1:0] leds,
  output logic            pronto,
  output logic            ganhou,
  output logic            perdeu,
  output logic            db_timeout,
  output logic [3:0]      db_estado,
  output logic [AW-1:0]   db_rodada,
  output logic [AW-1:0]   db_jogada,
  output logic [NBOT-1:0] db_ultima
);

  localparam int unsigned TMAX0 = (TIMEOUT_CYC > SHOW_CYC) ? TIMEOUT_CYC : SHOW_CYC;
  localparam int unsigned TMAX  = (TMAX0 > GAP_CYC) ? TMAX0 : GAP_CYC;
  localparam int unsigned TW    = $clog2(TMAX + 1);

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);

  typedef enum logic [3:0] {
    StInicial    = 4'd0,
    StPrepara    = 4'd1,
    StMostraLed  = 4'd2,
    StMostraGap  = 4'd3,
    StEspera     = 4'd4,
    StCompara    = 4'd5,
    StProxJogada = 4'd6,
    StProxRodada = 4'd7,
    StFimAcerto  = 4'd8,
    StFimErro    = 4'd9,
    StFimTimeout = 4'd10
  } estado_e;

  estado_e         r_estado;
  logic [NBOT-1:0] r_mem [MAXSEQ];
  logic [NBOT-1:0] r_botoes_q;
  logic [NBOT-1:0] r_ultima;
  logic [AW-1:0]   r_rodada;
  logic [AW-1:0]   r_jogada;
  logic [AW-1:0]   r_limite;
  logic [TW-1:0]   r_timer;
  logic            r_pronto;
  logic            r_ganhou;
  logic            r_perdeu;
  logic            r_timeout;

  logic            w_press;
  logic            w_acerto;
  logic            w_carga_ok;
  logic [AW-1:0]   w_limite;
  logic [NBOT-1:0] w_leds;

  // Clamp only matters when MAXSEQ is not a power of two.
  if ((1 << AW) == MAXSEQ) begin : g_lim_full
    assign w_limite = limite;
  end else begin : g_lim_clamp
    localparam logic [AW-1:0] LimMax = AW'(MAXSEQ - 1);
    assign w_limite = (limite > LimMax) ? LimMax : limite;
  end

  assign w_press    = (botoes != '0) && (r_botoes_q == '0);
  assign w_acerto   = (r_ultima == r_mem[r_jogada]);
  assign w_carga_ok = (r_estado == StInicial) || (r_estado == StFimAcerto) ||
                      (r_estado == StFimErro) || (r_estado == StFimTimeout);

  // Button history for edge detection; runs every cycle so a held button never counts.
  always_ff @(posedge clock) begin
    r_botoes_q <= botoes;
  end

  // Sequence RAM write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset && carrega && w_carga_ok) begin
      r_mem[end_carga] <= dado_carga;
    end
  end

  // Game FSM with its counters and result flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado  <= StInicial;
      r_ultima  <= '0;
      r_rodada  <= '0;
      r_jogada  <= '0;
      r_limite  <= '0;
      r_timer   <= '0;
      r_pronto  <= 1'b0;
      r_ganhou  <= 1'b0;
      r_perdeu  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_estado)
        StInicial: if (jogar) r_estado <= StPrepara;
        StPrepara: begin
          r_rodada  <= '0;
          r_jogada  <= '0;
          r_timer   <= '0;
          r_pronto  <= 1'b0;
          r_ganhou  <= 1'b0;
          r_perdeu  <= 1'b0;
          r_timeout <= 1'b0;
          r_limite  <= w_limite;
          r_estado  <= modo_mostra ? StMostraLed : StEspera;
        end
        StMostraLed: begin
          if (r_timer == SHOW_LAST) begin
            r_timer  <= '0;
            r_estado <= StMostraGap;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        StMostraGap: begin
          if (r_timer == GAP_LAST) begin
            r_timer <= '0;
            if (r_jogada < r_rodada) begin
              r_jogada <= r_jogada + AW'(1);
              r_estado <= StMostraLed;
            end else begin
              r_jogada <= '0;
              r_estado <= StEspera;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        StEspera: begin
          // A press in the expiry cycle takes priority over the timeout.
          if (w_press) begin
            r_ultima <= botoes;
            r_timer  <= '0;
            r_estado <= StCompara;
          end else if (r_timer == TO_LAST) begin
            r_timer   <= '0;
            r_pronto  <= 1'b1;
            r_perdeu  <= 1'b1;
            r_timeout <= 1'b1;
            r_estado  <= StFimTimeout;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        StCompara: begin
          if (!w_acerto) begin
            r_pronto <= 1'b1;
            r_perdeu <= 1'b1;
            r_estado <= StFimErro;
          end else if (r_jogada < r_rodada) begin
            r_estado <= StProxJogada;
          end else if (r_rodada == r_limite) begin
            r_pronto <= 1'b1;
            r_ganhou <= 1'b1;
            r_estado <= StFimAcerto;
          end else begin
            r_estado <= StProxRodada;
          end
        end
        StProxJogada: begin
          r_jogada <= r_jogada + AW'(1);
          r_timer  <= '0;
          r_estado <= StEspera;
        end
        StProxRodada: begin
          r_rodada <= r_rodada + AW'(1);
          r_jogada <= '0;
          r_timer  <= '0;
          r_estado <= modo_mostra ? StMostraLed : StEspera;
        end
        StFimAcerto, StFimErro, StFimTimeout: begin
          if (jogar) begin
            r_pronto  <= 1'b0;
            r_ganhou  <= 1'b0;
            r_perdeu  <= 1'b0;
            r_timeout <= 1'b0;
            r_estado  <= StPrepara;
          end
        end
        default: r_estado <= StInicial;
      endcase
    end
  end

  // LED drive decoded from the registered state; FIM_ERRO shows the expected answer.
  always_comb begin
    w_leds = '0;
    case (r_estado)
      StMostraLed, StFimErro: w_leds = r_mem[r_jogada];
      StFimAcerto:            w_leds = '1;
      default:                w_leds = '0;
    endcase
  end

  assign leds       = w_leds;
  assign pronto     = r_pronto;
  assign ganhou     = r_ganhou;
  assign perdeu     = r_perdeu;
  assign db_timeout = r_timeout;
  assign db_estado  = r_estado;
  assign db_rodada  = r_rodada;
  assign db_jogada  = r_jogada;
  assign db_ultima  = r_ultima;

endmodule
